dma_wr_engine: RTL and testbench
================================

Name: dma_wr_engine

Overview:
- Endpoint-side DMA write engine: accepts host register writes to DMABASE/DMACTRL and streams N × 128-byte PCIe MWr TLPs of source data into RC memory.
- After the last data TLP it issues one 8-byte MWr carrying a completion token to DMABASE.
- Sits between the BAR register decoder and the 64-bit Avalon-ST TX port of the PCIe hard IP. The host polls RC memory for the token.

Parameters:
- TOKEN, 64'hCAFEF00DC0DEFACE, completion QW written to DMABASE.
- DATA_OFFSET, 32'h40, byte offset of the first data TLP from DMABASE.
- CNT_WIDTH, 16, width of the TLP-count field in DMACTRL.

Ports:
- clk_in  in  1  PCIe core clock.
- rstn  in  1  Asynchronous active-low reset.
- rid_in  in  16  Requester ID {bus, dev, fn}.
- cfg_wrValid_in  in  1  Register write strobe.
- cfg_wrAddr_in  in  1  Register index: 0=DMABASE, 1=DMACTRL.
- cfg_wrData_in  in  32  Register write data.
- src_data_in  in  64  Payload QW.
- src_valid_in  in  1  Payload valid.
- src_ready_out  out  1  Payload accepted.
- tx_data_out  out  64  TX beat.
- tx_sop_out  out  1  Start of packet.
- tx_eop_out  out  1  End of packet.
- tx_valid_out  out  1  Beat valid.
- tx_ready_in  in  1  Core ready (zero ready-latency).
- busy_out  out  1  Transfer in progress.

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low on rstn.
- Reset values: state=IDLE, base=0, remaining=0, tag=0, tx_valid_out=0, tx_sop_out=0, tx_eop_out=0, src_ready_out=0, busy_out=0, tx_data_out=0.
- A beat transfers on any cycle where tx_valid_out && tx_ready_in. Outputs hold while tx_ready_in=0.
- DMABASE write: base <= {wrData[31:3], 3'b000}.
  - Accepted in any state.
  - Affects only the next DMACTRL start; the in-flight transfer keeps its latched address.
- DMACTRL write in IDLE: remaining <= wrData[CNT_WIDTH-1:0] and addr <= base + DATA_OFFSET.
  - If the count is 0, the write is a no-op and the engine stays in IDLE.
  - DMACTRL writes outside IDLE are ignored.
- busy_out = (state != IDLE). It rises the cycle after an accepted DMACTRL write.
- HDR0: tx_data_out = {DW1, DW0}, sop=1.
  - DW0 = 32'h4000_0020 (3DW MWr, length 32 DW).
  - DW1 = {rid_in, tag, 4'hF, 4'hF}.
  - On transfer, go to HDR1.
- HDR1: tx_data_out = {32'h0, addr}, the Altera qword-aligned 3DW layout. On transfer, go to DATA with qcnt=0.
- DATA: tx_valid_out = src_valid_in, src_ready_out = tx_ready_in, tx_data_out = src_data_in.
  - eop=1 when qcnt=15.
  - qcnt increments on each transfer.
  - A source stall holds the packet open with valid low.
- End of a DATA TLP (transfer with qcnt=15):
  - tag <= tag+1 (8-bit wrap); addr <= addr+128 (32-bit wrap); remaining <= remaining-1.
  - If remaining was >1, go to HDR0; otherwise go to TOK0.
- TOK0: DW0 = 32'h4000_0002, DW1 = {rid_in, tag, 4'hF, 4'hF}, sop=1.
- TOK1: {32'h0, base_latched}.
- TOKD: tx_data_out = TOKEN, eop=1. On transfer: tag+1, go to IDLE.
- base_latched is captured at DMACTRL acceptance.
- src_ready_out=0 outside DATA. Source data is never consumed during header or token beats.
- Reset mid-packet: outputs clear asynchronously. The partial TLP is abandoned, and the engine returns to IDLE with the count cleared.

Decomposition:
- Shared package dma_pkg holds:
  - state enum {IDLE, HDR0, HDR1, DATA, TOK0, TOK1, TOKD};
  - register indices DMABASE=0, DMACTRL=1;
  - MWr fmt/type constant 7'b10_00000;
  - TLP_QWS=16.
- Optional sub-module tlp_hdr_mwr3: combinational packer of {length, rid, tag, addr} into DW0/DW1/DW2, reused by future read engines.
- The FSM remains in dma_wr_engine.

Test Plan:
- Single TLP:
  - Stimulus: rid=16'h0100, DMABASE=0x20, DMACTRL=1, source supplies 16 QWs, tx_ready_in=1.
  - Required: beats 4000_0020/0100_00FF, addr 0x60, 16 data beats with eop on the 16th; then token TLP with 4000_0002/0100_01FF, addr 0x20, data CAFEF00DC0DEFACE.
  - busy_out is high from the cycle after the DMACTRL write until the cycle after TOKD.
- Multi-TLP:
  - Stimulus: DMACTRL=3.
  - Required: addresses 0x60, 0xE0, 0x160; tags 0, 1, 2; token with tag 3.
  - Exactly 48 src transfers.
- Backpressure:
  - Stimulus: random tx_ready_in and src_valid_in gaps.
  - Required: beat contents and order identical to the no-stall case.
  - No beat is duplicated or dropped; sop/eop hold stable while stalled.
- Busy ignore and no-op count:
  - Stimulus: write DMACTRL=5 while busy; separately, write DMACTRL=0 in IDLE.
  - Required: the second DMACTRL is ignored and only the original count is sent; DMACTRL=0 causes no TX traffic.
  - A DMABASE write while busy only affects the next transfer's token address.
- Wrap:
  - Stimulus: base=0xFFFFFFC0 with count 2; and 256 consecutive TLPs.
  - Required: data addresses 0x00000000, then 0x00000080; the tag wraps from 0xFF to 0x00.
- Reset mid-DATA:
  - Stimulus: assert rstn low at qcnt=7.
  - Required: all outputs are 0 immediately; after release the engine is in IDLE, and a new DMACTRL=1 produces a clean TLP with tag 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA write engine and its TLP header packer.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    TOK0,
    TOK1,
    TOKD
  } state_t;

  localparam logic REG_DMABASE = 1'b0;
  localparam logic REG_DMACTRL = 1'b1;

  localparam logic [6:0] FMT_TYPE_MWR3 = 7'b10_00000;

  localparam int unsigned TLP_QWS = 16;
  localparam int unsigned QCNT_W  = 4;

  // Payload lengths in DWs: a full data TLP and the single-QW completion token.
  localparam logic [9:0] DATA_LEN_DW  = 10'd32;
  localparam logic [9:0] TOKEN_LEN_DW = 10'd2;

endpackage

// File: rtl/tlp_hdr_mwr3.sv
// Combinational packer for a 3DW memory-write TLP header (no TC/attr/TD/EP, all byte enables set).
module tlp_hdr_mwr3
  import dma_pkg::*;
(
  input  logic [9:0]  length,
  input  logic [15:0] rid,
  input  logic [7:0]  tag,
  input  logic [31:0] addr,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2
);

  assign dw0 = {1'b0, FMT_TYPE_MWR3, 8'h00, 6'h00, length};
  assign dw1 = {rid, tag, 4'hF, 4'hF};
  assign dw2 = {addr[31:2], 2'b00};

endmodule

// File: rtl/dma_wr_engine.sv
// Endpoint DMA write engine: streams N x 128-byte MWr TLPs of source data, then one
// 8-byte MWr carrying a completion token to the programmed base address.
module dma_wr_engine
  import dma_pkg::*;
#(
  parameter logic [63:0] TOKEN       = 64'hCAFEF00DC0DEFACE,
  parameter logic [31:0] DATA_OFFSET = 32'h40,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic        clk_in,
  input  logic        rstn,
  input  logic [15:0] rid_in,
  input  logic        cfg_wrValid_in,
  input  logic        cfg_wrAddr_in,
  input  logic [31:0] cfg_wrData_in,
  input  logic [63:0] src_data_in,
  input  logic        src_valid_in,
  output logic        src_ready_out,
  output logic [63:0] tx_data_out,
  output logic        tx_sop_out,
  output logic        tx_eop_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in,
  output logic        busy_out
);

  state_t                 state, state_next;
  logic [31:0]            base;
  logic [31:0]            base_latched;
  logic [31:0]            addr;
  logic [CNT_WIDTH-1:0]   remaining;
  logic [7:0]             tag;
  logic [QCNT_W-1:0]      qcnt;

  logic                   start;
  logic                   last_qw;
  logic                   data_xfer;
  logic                   tok_hdr;
  logic [31:0]            hdr_dw0, hdr_dw1, hdr_dw2;

  assign start     = (state == IDLE) && cfg_wrValid_in && (cfg_wrAddr_in == REG_DMACTRL)
                     && (cfg_wrData_in[CNT_WIDTH-1:0] != '0);
  assign last_qw   = (qcnt == QCNT_W'(TLP_QWS - 1));
  assign data_xfer = (state == DATA) && src_valid_in && tx_ready_in;
  assign tok_hdr   = (state == TOK0) || (state == TOK1);
  assign busy_out  = (state != IDLE);

  tlp_hdr_mwr3 u_hdr (
    .length (tok_hdr ? TOKEN_LEN_DW : DATA_LEN_DW),
    .rid    (rid_in),
    .tag    (tag),
    .addr   (tok_hdr ? base_latched : addr),
    .dw0    (hdr_dw0),
    .dw1    (hdr_dw1),
    .dw2    (hdr_dw2)
  );

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are decoded from state so a reset clears the TX port without waiting for a clock.
  always_comb begin
    state_next    = state;
    tx_valid_out  = 1'b0;
    tx_sop_out    = 1'b0;
    tx_eop_out    = 1'b0;
    tx_data_out   = '0;
    src_ready_out = 1'b0;
    case (state)
      IDLE: if (start) state_next = HDR0;
      HDR0, TOK0: begin
        tx_valid_out = 1'b1;
        tx_sop_out   = 1'b1;
        tx_data_out  = {hdr_dw1, hdr_dw0};
        if (tx_ready_in) state_next = (state == HDR0) ? HDR1 : TOK1;
      end
      HDR1, TOK1: begin
        tx_valid_out = 1'b1;
        tx_data_out  = {32'h0, hdr_dw2};
        if (tx_ready_in) state_next = (state == HDR1) ? DATA : TOKD;
      end
      DATA: begin
        tx_valid_out  = src_valid_in;
        src_ready_out = tx_ready_in;
        tx_data_out   = src_data_in;
        tx_eop_out    = last_qw;
        if (data_xfer && last_qw)
          state_next = (remaining > CNT_WIDTH'(1)) ? HDR0 : TOK0;
      end
      TOKD: begin
        tx_valid_out = 1'b1;
        tx_eop_out   = 1'b1;
        tx_data_out  = TOKEN;
        if (tx_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      base         <= '0;
      base_latched <= '0;
      addr         <= '0;
      remaining    <= '0;
      tag          <= '0;
      qcnt         <= '0;
    end else begin
      if (cfg_wrValid_in && (cfg_wrAddr_in == REG_DMABASE))
        base <= {cfg_wrData_in[31:3], 3'b000};
      if (start) begin
        remaining    <= cfg_wrData_in[CNT_WIDTH-1:0];
        addr         <= base + DATA_OFFSET;
        base_latched <= base;
      end
      if ((state == HDR1) && tx_ready_in)
        qcnt <= '0;
      if (data_xfer) begin
        qcnt <= qcnt + QCNT_W'(1);
        if (last_qw) begin
          tag       <= tag + 8'd1;
          addr      <= addr + 32'd128;
          remaining <= remaining - CNT_WIDTH'(1);
        end
      end
      if ((state == TOKD) && tx_ready_in)
        tag <= tag + 8'd1;
    end
  end

endmodule

// File: tb/tb_dma_wr_engine.sv
// Randomized bench for dma_wr_engine against a transaction-level model of the expected TX stream.
module tb_dma_wr_engine;

  localparam logic [63:0] TOKEN = 64'hCAFEF00DC0DEFACE;

  logic        clk_in = 1'b0;
  logic        rstn;
  logic [15:0] rid_in;
  logic        cfg_wrValid_in;
  logic        cfg_wrAddr_in;
  logic [31:0] cfg_wrData_in;
  logic [63:0] src_data_in;
  logic        src_valid_in;
  logic        src_ready_out;
  logic [63:0] tx_data_out;
  logic        tx_sop_out;
  logic        tx_eop_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic        busy_out;

  dma_wr_engine dut (
    .clk_in         (clk_in),
    .rstn           (rstn),
    .rid_in         (rid_in),
    .cfg_wrValid_in (cfg_wrValid_in),
    .cfg_wrAddr_in  (cfg_wrAddr_in),
    .cfg_wrData_in  (cfg_wrData_in),
    .src_data_in    (src_data_in),
    .src_valid_in   (src_valid_in),
    .src_ready_out  (src_ready_out),
    .tx_data_out    (tx_data_out),
    .tx_sop_out     (tx_sop_out),
    .tx_eop_out     (tx_eop_out),
    .tx_valid_out   (tx_valid_out),
    .tx_ready_in    (tx_ready_in),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        is_data;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] src_q[$];

  int          checks = 0;
  int          failures = 0;
  int          rdy_pct = 100;
  int          src_pct = 100;
  int          src_xfers = 0;
  int          beats_seen = 0;
  logic [31:0] base_m = '0;
  logic [7:0]  tag_m = '0;
  logic        src_taken = 1'b0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_out = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Expected stream for one accepted DMACTRL: n data TLPs then the token TLP.
  task automatic build(input int n);
    logic [31:0] a;
    logic [63:0] d;
    a = base_m + 32'h40;
    for (int t = 0; t < n; t++) begin
      exp_q.push_back('{{rid_in, tag_m, 8'hFF, 32'h4000_0020}, 1'b1, 1'b0, 1'b0});
      exp_q.push_back('{{32'h0, a}, 1'b0, 1'b0, 1'b0});
      for (int q = 0; q < 16; q++) begin
        d = {$urandom, $urandom};
        src_q.push_back(d);
        exp_q.push_back('{d, 1'b0, (q == 15), 1'b1});
      end
      tag_m = tag_m + 8'd1;
      a = a + 32'd128;
    end
    exp_q.push_back('{{rid_in, tag_m, 8'hFF, 32'h4000_0002}, 1'b1, 1'b0, 1'b0});
    exp_q.push_back('{{32'h0, base_m}, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{TOKEN, 1'b0, 1'b1, 1'b0});
    tag_m = tag_m + 8'd1;
  endtask

  task automatic step();
    beat_t e;
    logic  hold;
    @(negedge clk_in);
    check("busy", busy_out, exp_q.size() != 0);
    if (exp_q.size() == 0 || !exp_q[0].is_data)
      check("src_ready_outside_data", src_ready_out, 1'b0);
    if (prev_stall)
      check("stall_stable", {tx_data_out, tx_sop_out, tx_eop_out}, prev_out);
    if (tx_valid_out && tx_ready_in) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", tx_data_out, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", tx_data_out, e.data);
        check("beat_sop_eop", {tx_sop_out, tx_eop_out}, {e.sop, e.eop});
      end
    end
    prev_stall = tx_valid_out && !tx_ready_in;
    prev_out   = {tx_data_out, tx_sop_out, tx_eop_out};
    if (src_valid_in && src_ready_out) begin
      src_taken = 1'b1;
      src_xfers++;
    end
    @(posedge clk_in);
    #1;
    hold = src_valid_in && !src_taken;
    if (src_taken && src_q.size() != 0) void'(src_q.pop_front());
    src_taken = 1'b0;
    if (!hold) begin
      src_valid_in = (src_q.size() != 0) && ($urandom_range(99) < src_pct);
      src_data_in  = src_valid_in ? src_q[0] : {$urandom, $urandom};
    end
    tx_ready_in    = ($urandom_range(99) < rdy_pct);
    cfg_wrValid_in = 1'b0;
  endtask

  task automatic cfg_write(input logic a, input logic [31:0] d);
    logic accept;
    accept = a && (exp_q.size() == 0) && (d[15:0] != 16'h0);
    cfg_wrValid_in = 1'b1;
    cfg_wrAddr_in  = a;
    cfg_wrData_in  = d;
    step();
    if (!a) base_m = {d[31:3], 3'b000};
    else if (accept) build(int'(d[15:0]));
  endtask

  task automatic run(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    step();
  endtask

  task automatic xfer(input logic [31:0] base, input int n, input string name);
    int s0;
    s0 = src_xfers;
    cfg_write(1'b0, base);
    cfg_write(1'b1, n);
    run(400 + n * 18 * 20);
    check(name, src_xfers - s0, n * 16);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    rstn = 1'b0;
    rid_in = 16'h0100;
    cfg_wrValid_in = 1'b0;
    cfg_wrAddr_in = 1'b0;
    cfg_wrData_in = '0;
    src_data_in = '0;
    src_valid_in = 1'b0;
    tx_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_outputs", {tx_data_out, tx_valid_out, tx_sop_out, tx_eop_out, src_ready_out, busy_out}, '0);
    @(negedge clk_in) rstn = 1'b1;
    @(posedge clk_in);
    #1;
    step();

    // Single TLP, then three back-to-back.
    xfer(32'h20, 1, "src_count_single");
    xfer(32'h20, 3, "src_count_multi");

    // Backpressure on both sides.
    rdy_pct = 50; src_pct = 60;
    rid_in = 16'($urandom);
    xfer({$urandom, 3'b0}, 4, "src_count_stall");
    xfer({$urandom, 3'b0}, 2, "src_count_stall2");

    // DMACTRL while busy is dropped; DMABASE while busy only moves the next token.
    rdy_pct = 80; src_pct = 80;
    cfg_write(1'b0, 32'h1000);
    cfg_write(1'b1, 32'd2);
    repeat (5) step();
    cfg_write(1'b1, 32'd5);
    cfg_write(1'b0, 32'h2000);
    run(2000);
    cfg_write(1'b1, 32'd1);
    run(1000);
    b0 = beats_seen;
    cfg_write(1'b1, 32'h0001_0000);
    repeat (20) step();
    check("ctrl0_beats", beats_seen - b0, 0);

    // Address wrap, then 256 TLPs to wrap the tag.
    xfer(32'hFFFF_FFC0, 2, "src_count_wrap");
    rdy_pct = 95; src_pct = 95;
    xfer(32'h8000_0000, 256, "src_count_256");

    // Reset while qcnt=7 inside a data TLP.
    rdy_pct = 100; src_pct = 100;
    cfg_write(1'b0, 32'h300);
    cfg_write(1'b1, 32'd1);
    b0 = beats_seen;
    for (int c = 0; c < 200 && (beats_seen - b0) < 9; c++) step();
    check("pre_reset_beats", beats_seen - b0, 9);
    #2 rstn = 1'b0;
    #1;
    check("reset_mid_outputs", {tx_data_out, tx_valid_out, tx_sop_out, tx_eop_out, src_ready_out, busy_out}, '0);
    exp_q.delete();
    src_q.delete();
    tag_m = '0;
    base_m = '0;
    src_valid_in = 1'b0;
    src_taken = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk_in) rstn = 1'b1;
    @(posedge clk_in);
    #1;
    repeat (3) step();
    xfer(32'h440, 1, "src_count_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
